// File: rtl/scudsp_dma_if.sv
// Bus-side request/acknowledge bundle between the SCU DSP DMA engine and the SCU bus arbiter.
// Latency: none, signals only.
// Backpressure: the master holds BUS_REQ/BUS_WE/BUS_A stable until the slave returns BUS_ACK.
// Ports: BUS_A byte address, BUS_DO write data, BUS_DI read data, BUS_REQ/BUS_WE/BUS_ACK handshake.
interface scudsp_dma_if;
    logic [26:0] BUS_A;
    logic [31:0] BUS_DO;
    logic [31:0] BUS_DI;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic        BUS_ACK;

    modport master (
        output BUS_A,
        output BUS_DO,
        output BUS_REQ,
        output BUS_WE,
        input  BUS_DI,
        input  BUS_ACK
    );

    modport slave (
        input  BUS_A,
        input  BUS_DO,
        input  BUS_REQ,
        input  BUS_WE,
        output BUS_DI,
        output BUS_ACK
    );
endinterface

// File: rtl/scudsp_dma.sv
// SCU DSP DMA engine: moves CNT words between the external bus and a DSP data RAM bank or program RAM.
// Latency: ST to first bus request / RAM read is 1 CE cycle; each word costs 1 + bus-wait CE cycles.
// Backpressure: bus request is held until BUS_ACK is seen in a CE=1 cycle; CE=0 freezes everything.
// Ports: command fields (ST/DIR/PRGW/RAMS/ADDI/HOLD/CNT/RA0/WA0), address write-back (RA0_*/WA0_*),
//        bus interface (bus), data RAM (RAM_Q/RAM_D/RAM_WE/CT_INC), program RAM (PRG_WE/PRG_A), BUSY/DONE.
module scudsp_dma #(
    parameter int PRG_AW = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CE,
    input  logic              ST,
    input  logic              DIR,
    input  logic              PRGW,
    input  logic [1:0]        RAMS,
    input  logic [2:0]        ADDI,
    input  logic              HOLD,
    input  logic [7:0]        CNT,
    input  logic [24:0]       RA0,
    input  logic [24:0]       WA0,
    output logic [24:0]       RA0_OUT,
    output logic [24:0]       WA0_OUT,
    output logic              RA0_UPD,
    output logic              WA0_UPD,
    scudsp_dma_if.master      bus,
    input  logic [31:0]       RAM_Q,
    output logic [31:0]       RAM_D,
    output logic [3:0]        RAM_WE,
    output logic [3:0]        CT_INC,
    output logic              PRG_WE,
    output logic [PRG_AW-1:0] PRG_A,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRD,
        S_RWR,
        S_RRD,
        S_BWR,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [26:0]       addr_q, addr_d;
    logic [PRG_AW-1:0] prg_a_q, prg_a_d;
    logic [31:0]       data_q, data_d;
    logic              dir_q, dir_d;
    logic              prgw_q, prgw_d;
    logic [1:0]        rams_q, rams_d;
    logic [2:0]        addi_q, addi_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;

    logic [26:0]       addr_inc;
    logic [3:0]        bank_oh;
    logic [3:0]        ram_we;
    logic [3:0]        ct_inc;
    logic              prg_we;
    logic              done;
    logic              ra0_upd;
    logic              wa0_upd;

    // Code 0 is a fixed address; codes 1..7 step by 4..256 bytes.
    always_comb begin
        case (addi_q)
            3'd1:    addr_inc = 27'd4;
            3'd2:    addr_inc = 27'd8;
            3'd3:    addr_inc = 27'd16;
            3'd4:    addr_inc = 27'd32;
            3'd5:    addr_inc = 27'd64;
            3'd6:    addr_inc = 27'd128;
            3'd7:    addr_inc = 27'd256;
            default: addr_inc = 27'd0;
        endcase
    end

    assign bank_oh = 4'b0001 << rams_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        prg_a_d = prg_a_q;
        data_d  = data_q;
        dir_d   = dir_q;
        prgw_d  = prgw_q;
        rams_d  = rams_q;
        addi_d  = addi_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        ram_we  = 4'b0000;
        ct_inc  = 4'b0000;
        prg_we  = 1'b0;
        done    = 1'b0;
        ra0_upd = 1'b0;
        wa0_upd = 1'b0;

        if (CE) begin
            case (state_q)
                S_IDLE: begin
                    if (ST) begin
                        dir_d   = DIR;
                        // Program RAM is only a write target; a read command falls back to the data bank.
                        prgw_d  = PRGW & ~DIR;
                        rams_d  = RAMS;
                        addi_d  = ADDI;
                        hold_d  = HOLD;
                        cnt_d   = (CNT == 8'd0) ? 9'd256 : {1'b0, CNT};
                        addr_d  = DIR ? {WA0, 2'b00} : {RA0, 2'b00};
                        prg_a_d = '0;
                        busy_d  = 1'b1;
                        state_d = DIR ? S_RRD : S_BRD;
                    end
                end
                S_BRD: begin
                    if (bus.BUS_ACK) begin
                        data_d  = bus.BUS_DI;
                        addr_d  = addr_q + addr_inc;
                        state_d = S_RWR;
                    end
                end
                S_RWR: begin
                    if (prgw_q) begin
                        prg_we  = 1'b1;
                        prg_a_d = prg_a_q + PRG_AW'(1);
                    end else begin
                        ram_we = bank_oh;
                        ct_inc = bank_oh;
                    end
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? S_FIN : S_BRD;
                end
                S_RRD: begin
                    data_d  = RAM_Q;
                    ct_inc  = bank_oh;
                    state_d = S_BWR;
                end
                S_BWR: begin
                    if (bus.BUS_ACK) begin
                        addr_d  = addr_q + addr_inc;
                        cnt_d   = cnt_q - 9'd1;
                        state_d = (cnt_q == 9'd1) ? S_FIN : S_RRD;
                    end
                end
                S_FIN: begin
                    done    = 1'b1;
                    ra0_upd = ~hold_q & ~dir_q;
                    wa0_upd = ~hold_q & dir_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Request and write-enable follow the next state so they are registered and
        // drop on the edge that consumes the ACK.
        bus_req_d = (state_d == S_BRD) || (state_d == S_BWR);
        bus_we_d  = (state_d == S_BWR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= 9'd0;
            addr_q    <= 27'd0;
            prg_a_q   <= '0;
            data_q    <= 32'd0;
            dir_q     <= 1'b0;
            prgw_q    <= 1'b0;
            rams_q    <= 2'd0;
            addi_q    <= 3'd0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            prg_a_q   <= prg_a_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            prgw_q    <= prgw_d;
            rams_q    <= rams_d;
            addi_q    <= addi_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            bus_req_q <= bus_req_d;
            bus_we_q  <= bus_we_d;
        end
    end

    assign bus.BUS_A   = addr_q;
    assign bus.BUS_DO  = data_q;
    assign bus.BUS_REQ = bus_req_q;
    assign bus.BUS_WE  = bus_we_q;

    assign RAM_D   = data_q;
    assign RAM_WE  = ram_we;
    assign CT_INC  = ct_inc;
    assign PRG_WE  = prg_we;
    assign PRG_A   = prg_a_q;
    assign BUSY    = busy_q;
    assign DONE    = done;
    assign RA0_UPD = ra0_upd;
    assign WA0_UPD = wa0_upd;
    assign RA0_OUT = addr_q[26:2];
    assign WA0_OUT = addr_q[26:2];

endmodule

// File: tb/tb_scudsp_dma.sv
// Directed bench for scudsp_dma: hand-computed bus addresses, RAM strobes, write-back and timing.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled at that point.
// Backpressure: the bench plays the bus slave, raising BUS_ACK after a chosen number of request cycles.
module tb_scudsp_dma;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        CE = 1'b0;
    logic        ST = 1'b0;
    logic        DIR = 1'b0;
    logic        PRGW = 1'b0;
    logic [1:0]  RAMS = 2'd0;
    logic [2:0]  ADDI = 3'd0;
    logic        HOLD = 1'b0;
    logic [7:0]  CNT = 8'd0;
    logic [24:0] RA0 = 25'd0;
    logic [24:0] WA0 = 25'd0;
    logic [31:0] RAM_Q = 32'd0;

    logic [24:0] RA0_OUT, WA0_OUT;
    logic        RA0_UPD, WA0_UPD;
    logic [31:0] RAM_D;
    logic [3:0]  RAM_WE, CT_INC;
    logic        PRG_WE;
    logic [7:0]  PRG_A;
    logic        BUSY, DONE;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit finished = 1'b0;

    scudsp_dma_if bus ();

    scudsp_dma #(.PRG_AW(8)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CE      (CE),
        .ST      (ST),
        .DIR     (DIR),
        .PRGW    (PRGW),
        .RAMS    (RAMS),
        .ADDI    (ADDI),
        .HOLD    (HOLD),
        .CNT     (CNT),
        .RA0     (RA0),
        .WA0     (WA0),
        .RA0_OUT (RA0_OUT),
        .WA0_OUT (WA0_OUT),
        .RA0_UPD (RA0_UPD),
        .WA0_UPD (WA0_UPD),
        .bus     (bus),
        .RAM_Q   (RAM_Q),
        .RAM_D   (RAM_D),
        .RAM_WE  (RAM_WE),
        .CT_INC  (CT_INC),
        .PRG_WE  (PRG_WE),
        .PRG_A   (PRG_A),
        .BUSY    (BUSY),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Entered in BRD; ACK arrives in the n-th request cycle with data {5'h1A, address}.
    task automatic rd_word(input logic [26:0] ea, input int n, input bit prg,
                           input logic [7:0] epa, input logic [3:0] ebank);
        chk("brd_req", bus.BUS_REQ, 1'b1);
        chk("brd_we", bus.BUS_WE, 1'b0);
        chk("brd_a", bus.BUS_A, ea);
        for (int i = 1; i < n; i++) tick();
        if (n > 1) begin
            chk("brd_hold_req", bus.BUS_REQ, 1'b1);
            chk("brd_hold_a", bus.BUS_A, ea);
        end
        bus.BUS_DI  = {5'h1A, ea};
        bus.BUS_ACK = 1'b1;
        tick();
        bus.BUS_ACK = 1'b0;
        chk("rwr_req", bus.BUS_REQ, 1'b0);
        chk("rwr_d", RAM_D, {5'h1A, ea});
        chk("rwr_done", DONE, 1'b0);
        if (prg) begin
            chk("rwr_prg_we", PRG_WE, 1'b1);
            chk("rwr_prg_a", PRG_A, epa);
            chk("rwr_ram_we_p", RAM_WE, 4'b0000);
        end else begin
            chk("rwr_ram_we", RAM_WE, ebank);
            chk("rwr_ct_inc", CT_INC, ebank);
            chk("rwr_prg_we_d", PRG_WE, 1'b0);
        end
        tick();
    endtask

    // Entered in RRD; RAM supplies q, then the bus write is acknowledged after n cycles.
    task automatic wr_word(input logic [26:0] ea, input logic [31:0] q,
                           input logic [3:0] ebank, input int n);
        chk("rrd_ct_inc", CT_INC, ebank);
        chk("rrd_req", bus.BUS_REQ, 1'b0);
        RAM_Q = q;
        tick();
        chk("bwr_req", bus.BUS_REQ, 1'b1);
        chk("bwr_we", bus.BUS_WE, 1'b1);
        chk("bwr_a", bus.BUS_A, ea);
        chk("bwr_do", bus.BUS_DO, q);
        chk("bwr_ct_inc", CT_INC, 4'b0000);
        for (int i = 1; i < n; i++) tick();
        bus.BUS_ACK = 1'b1;
        tick();
        bus.BUS_ACK = 1'b0;
    endtask

    initial begin
        #500000;
        if (!finished) begin
            errors++;
            $error("FAIL timeout waiting for test completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        bus.BUS_DI  = 32'd0;
        bus.BUS_ACK = 1'b0;
        CE = 1'b1;
        #12;
        chk("rst_req", bus.BUS_REQ, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_a", bus.BUS_A, 27'd0);
        chk("rst_prg_a", PRG_A, 8'd0);
        chk("rst_ram_we", RAM_WE, 4'b0000);
        RST_N = 1'b1;
        tick();

        // Bus -> data RAM bank 2, three words, ACK in the first request cycle.
        DIR = 1'b0; RAMS = 2'd2; CNT = 8'd3; ADDI = 3'd1; RA0 = 25'h100; ST = 1'b1;
        cyc = 0;
        tick();
        ST = 1'b0;
        chk("t1_busy", BUSY, 1'b1);
        rd_word(27'h400, 1, 1'b0, 8'd0, 4'b0100);
        rd_word(27'h404, 1, 1'b0, 8'd0, 4'b0100);
        rd_word(27'h408, 1, 1'b0, 8'd0, 4'b0100);
        chk("t1_cycles", cyc, 7);
        chk("t1_done", DONE, 1'b1);
        chk("t1_ra0_upd", RA0_UPD, 1'b1);
        chk("t1_wa0_upd", WA0_UPD, 1'b0);
        chk("t1_ra0_out", RA0_OUT, 25'h103);
        chk("t1_fin_busy", BUSY, 1'b1);
        tick();
        chk("t1_idle_done", DONE, 1'b0);
        chk("t1_idle_busy", BUSY, 1'b0);
        chk("t1_idle_upd", RA0_UPD, 1'b0);

        // RAM bank 0 -> bus, fixed address; a second ST mid-transfer must be ignored.
        DIR = 1'b1; RAMS = 2'd0; CNT = 8'd2; ADDI = 3'd0; WA0 = 25'h20; ST = 1'b1;
        tick();
        wr_word(27'h80, 32'h1111_2222, 4'b0001, 1);
        ST = 1'b0;
        wr_word(27'h80, 32'h3333_4444, 4'b0001, 2);
        chk("t2_done", DONE, 1'b1);
        chk("t2_wa0_upd", WA0_UPD, 1'b1);
        chk("t2_ra0_upd", RA0_UPD, 1'b0);
        chk("t2_wa0_out", WA0_OUT, 25'h20);
        tick();
        chk("t2_idle_busy", BUSY, 1'b0);
        chk("t2_idle_req", bus.BUS_REQ, 1'b0);

        // Program RAM fill, CNT=0 means 256 words.
        DIR = 1'b0; PRGW = 1'b1; CNT = 8'd0; ADDI = 3'd1; RA0 = 25'h0; ST = 1'b1;
        tick();
        ST = 1'b0;
        for (int i = 0; i < 256; i++) rd_word(27'(i * 4), 1, 1'b1, 8'(i), 4'b0000);
        chk("t3_done", DONE, 1'b1);
        chk("t3_prg_a_wrap", PRG_A, 8'd0);
        chk("t3_ra0_out", RA0_OUT, 25'h100);
        tick();
        chk("t3_idle_done", DONE, 1'b0);
        PRGW = 1'b0;

        // HOLD suppresses write-back; 256-byte stride.
        DIR = 1'b0; RAMS = 2'd1; CNT = 8'd2; ADDI = 3'd7; RA0 = 25'h10; HOLD = 1'b1; ST = 1'b1;
        tick();
        ST = 1'b0;
        rd_word(27'h040, 3, 1'b0, 8'd0, 4'b0010);
        rd_word(27'h140, 1, 1'b0, 8'd0, 4'b0010);
        chk("t4_done", DONE, 1'b1);
        chk("t4_ra0_upd", RA0_UPD, 1'b0);
        chk("t4_addr", RA0_OUT, 25'h90);
        tick();
        HOLD = 1'b0;

        // Address wrap at 2^27.
        DIR = 1'b0; RAMS = 2'd0; CNT = 8'd2; ADDI = 3'd1; RA0 = 25'h1FF_FFFF; ST = 1'b1;
        tick();
        ST = 1'b0;
        rd_word(27'h7FF_FFFC, 1, 1'b0, 8'd0, 4'b0001);
        rd_word(27'h000_0000, 1, 1'b0, 8'd0, 4'b0001);
        chk("t5_ra0_upd", RA0_UPD, 1'b1);
        chk("t5_ra0_out", RA0_OUT, 25'h1);
        tick();

        // CE=0 freezes state and strobes; ACK during CE=0 is not taken.
        DIR = 1'b0; RAMS = 2'd3; CNT = 8'd1; ADDI = 3'd0; RA0 = 25'h8; ST = 1'b1;
        tick();
        ST = 1'b0;
        CE = 1'b0; bus.BUS_DI = 32'hCAFE_F00D; bus.BUS_ACK = 1'b1;
        tick();
        chk("t6_ce0_req", bus.BUS_REQ, 1'b1);
        chk("t6_ce0_we", RAM_WE, 4'b0000);
        chk("t6_ce0_a", bus.BUS_A, 27'h20);
        CE = 1'b1;
        tick();
        bus.BUS_ACK = 1'b0;
        chk("t6_rwr_we", RAM_WE, 4'b1000);
        chk("t6_rwr_d", RAM_D, 32'hCAFE_F00D);
        CE = 1'b0;
        #1;
        chk("t6_gate_we", RAM_WE, 4'b0000);
        tick();
        chk("t6_frz_we", RAM_WE, 4'b0000);
        chk("t6_frz_done", DONE, 1'b0);
        CE = 1'b1;
        #1;
        chk("t6_resume_we", RAM_WE, 4'b1000);
        tick();
        chk("t6_done", DONE, 1'b1);
        chk("t6_ra0_out", RA0_OUT, 25'h8);
        CE = 1'b0;
        #1;
        chk("t6_done_gated", DONE, 1'b0);
        tick();
        CE = 1'b1;
        #1;
        chk("t6_done_again", DONE, 1'b1);
        tick();
        chk("t6_idle_busy", BUSY, 1'b0);

        // Reset in the middle of a bus read.
        DIR = 1'b0; RAMS = 2'd0; CNT = 8'd5; ADDI = 3'd1; RA0 = 25'h40; ST = 1'b1;
        tick();
        ST = 1'b0;
        chk("t7_req_pre", bus.BUS_REQ, 1'b1);
        RST_N = 1'b0;
        #1;
        chk("t7_req_rst", bus.BUS_REQ, 1'b0);
        chk("t7_busy_rst", BUSY, 1'b0);
        chk("t7_done_rst", DONE, 1'b0);
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t7_idle_req", bus.BUS_REQ, 1'b0);
            chk("t7_idle_busy", BUSY, 1'b0);
            chk("t7_idle_upd", RA0_UPD, 1'b0);
        end

        finished = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
